// File: rtl/em_pkg.sv
// Shared types and constants for the execute-to-memory pipeline register.
// Control bits are packed MSB-first as {PCSrc, RegWrite, MemWrite, MemtoReg}.
package em_pkg;

  localparam int EM_CTRL_W = 4;

  localparam int CTRL_PCSRC    = 3;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } em_state_t;

endpackage

// File: rtl/pipe_reg_em_hs_sat_counter.sv
// Saturating up-counter used for the E/M stall and flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_reg_em_hs.sv
// E/M pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and saturating stall/flush statistics.
module pipe_reg_em_hs
  import em_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemtoRegE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WA3E,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_W-1:0]  WA3M,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic [EM_CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]    alu;
    logic [DATA_W-1:0]    wdata;
    logic [REG_W-1:0]     wa3;
  } em_entry_t;

  em_state_t state_q, state_d;
  em_entry_t main_q, skid_q, in_entry;
  logic      load_main, main_from_skid, load_skid;
  logic      accept, consume;

  assign in_entry.ctrl  = {PCSrcE, RegWriteE, MemWriteE, MemtoRegE};
  assign in_entry.alu   = ALUResultE;
  assign in_entry.wdata = WriteDataE;
  assign in_entry.wa3   = WA3E;

  // Ready depends on registered state only, so no input reaches e_ready.
  assign e_ready = (state_q != SKID);
  assign m_valid = (state_q != EMPTY);
  assign accept  = e_valid & e_ready;
  assign consume = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            load_main = 1'b1;
          end
        end
        FULL: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (consume) begin
            state_d        = FULL;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flush only drops validity; stale payload stays in the entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign PCSrcM     = main_q.ctrl[CTRL_PCSRC]    & m_valid;
  assign RegWriteM  = main_q.ctrl[CTRL_REGWRITE] & m_valid;
  assign MemWriteM  = main_q.ctrl[CTRL_MEMWRITE] & m_valid;
  assign MemtoRegM  = main_q.ctrl[CTRL_MEMTOREG];
  assign ALUResultM = main_q.alu;
  assign WriteDataM = main_q.wdata;
  assign WA3M       = main_q.wa3;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (m_valid & ~m_ready),
    .count (stall_cnt)
  );

  // Any non-EMPTY state holds at least one valid entry.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush & m_valid),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_reg_em_hs.sv
// Directed self-checking bench for pipe_reg_em_hs; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_pipe_reg_em_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, e_valid, m_ready;
  logic        PCSrcE, RegWriteE, MemWriteE, MemtoRegE;
  logic [31:0] ALUResultE, WriteDataE;
  logic [2:0]  WA3E;

  logic        e_ready, m_valid, PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  WA3M;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_e_ready, s_m_valid, s_PCSrcM, s_RegWriteM, s_MemWriteM, s_MemtoRegM;
  logic [31:0] s_ALUResultM, s_WriteDataM;
  logic [2:0]  s_WA3M;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  pipe_reg_em_hs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .e_valid(e_valid), .e_ready(e_ready),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .m_valid(m_valid), .m_ready(m_ready),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_reg_em_hs #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .e_valid(e_valid), .e_ready(s_e_ready),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .m_valid(s_m_valid), .m_ready(m_ready),
    .PCSrcM(s_PCSrcM), .RegWriteM(s_RegWriteM), .MemWriteM(s_MemWriteM), .MemtoRegM(s_MemtoRegM),
    .ALUResultM(s_ALUResultM), .WriteDataM(s_WriteDataM), .WA3M(s_WA3M),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // ctrl is {PCSrc, RegWrite, MemWrite, MemtoReg}; WriteData is ALUResult + 0x100.
  task automatic applyStimulus(input logic ev, input logic [3:0] ctrl, input logic [31:0] alu,
                               input logic [2:0] wa, input logic mr, input logic fl);
    e_valid    = ev;
    {PCSrcE, RegWriteE, MemWriteE, MemtoRegE} = ctrl;
    ALUResultE = alu;
    WriteDataE = alu + 32'h100;
    WA3E       = wa;
    m_ready    = mr;
    flush      = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      miss_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'h0, 3'd0, 1'b1, 1'b0);
    #12;
    checkOutput("rst_m_valid", 64'(m_valid), 64'h0);
    checkOutput("rst_alu", 64'(ALUResultM), 64'h0);
    checkOutput("rst_wdata", 64'(WriteDataM), 64'h0);
    checkOutput("rst_wa3", 64'(WA3M), 64'h0);
    checkOutput("rst_ctrl", 64'({PCSrcM, RegWriteM, MemWriteM, MemtoRegM}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_e_ready", 64'(e_ready), 64'h1);
    checkOutput("rel_m_valid", 64'(m_valid), 64'h0);
    checkOutput("rel_stall", 64'(stall_cnt), 64'h0);
    checkOutput("rel_flush", 64'(flush_cnt), 64'h0);

    // Streaming 1,2,3 at full throughput
    applyStimulus(1'b1, 4'b0100, 32'd1, 3'd1, 1'b1, 1'b0);
    tick();
    checkOutput("s1_valid", 64'(m_valid), 64'h1);
    checkOutput("s1_alu", 64'(ALUResultM), 64'd1);
    checkOutput("s1_rw", 64'(RegWriteM), 64'h1);
    applyStimulus(1'b1, 4'b0100, 32'd2, 3'd2, 1'b1, 1'b0);
    tick();
    checkOutput("s2_alu", 64'(ALUResultM), 64'd2);
    checkOutput("s2_wa3", 64'(WA3M), 64'd2);
    applyStimulus(1'b1, 4'b0100, 32'd3, 3'd3, 1'b1, 1'b0);
    tick();
    checkOutput("s3_alu", 64'(ALUResultM), 64'd3);
    checkOutput("s3_wdata", 64'(WriteDataM), 64'h103);
    applyStimulus(1'b0, 4'b0000, 32'd0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", 64'(m_valid), 64'h0);
    checkOutput("drain_rw_gated", 64'(RegWriteM), 64'h0);
    checkOutput("drain_alu_held", 64'(ALUResultM), 64'd3);
    checkOutput("stream_stall", 64'(stall_cnt), 64'h0);

    // Back-pressure: A accepted, B lands in skid while m_ready is low
    applyStimulus(1'b1, 4'b0100, 32'hA, 3'd5, 1'b1, 1'b0);
    tick();
    checkOutput("bpA_alu", 64'(ALUResultM), 64'hA);
    applyStimulus(1'b1, 4'b0100, 32'hB, 3'd6, 1'b0, 1'b0);
    tick();
    checkOutput("bp_e_ready", 64'(e_ready), 64'h0);
    checkOutput("bp_alu_A", 64'(ALUResultM), 64'hA);
    checkOutput("bp_stall1", 64'(stall_cnt), 64'd1);
    applyStimulus(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_stall2", 64'(stall_cnt), 64'd2);
    checkOutput("bp_hold_A", 64'(ALUResultM), 64'hA);
    checkOutput("bp_hold_ready", 64'(e_ready), 64'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("bpB_alu", 64'(ALUResultM), 64'hB);
    checkOutput("bpB_wa3", 64'(WA3M), 64'd6);
    checkOutput("bpB_valid", 64'(m_valid), 64'h1);
    checkOutput("bpB_e_ready", 64'(e_ready), 64'h1);
    checkOutput("bpB_stall", 64'(stall_cnt), 64'd2);
    tick();
    checkOutput("bp_empty", 64'(m_valid), 64'h0);

    // Flush in SKID with C offered; D is in main with PCSrc/RegWrite/MemWrite set
    applyStimulus(1'b1, 4'b1110, 32'hD, 3'd4, 1'b1, 1'b0);
    tick();
    checkOutput("fD_ctrl", 64'({PCSrcM, RegWriteM, MemWriteM}), 64'h7);
    applyStimulus(1'b1, 4'b0100, 32'hE, 3'd7, 1'b0, 1'b0);
    tick();
    checkOutput("fskid_ready", 64'(e_ready), 64'h0);
    applyStimulus(1'b1, 4'b1111, 32'hC, 3'd2, 1'b0, 1'b1);
    tick();
    checkOutput("fl_valid", 64'(m_valid), 64'h0);
    checkOutput("fl_gated", 64'({PCSrcM, RegWriteM, MemWriteM}), 64'h0);
    checkOutput("fl_alu_kept", 64'(ALUResultM), 64'hD);
    checkOutput("fl_cnt", 64'(flush_cnt), 64'd1);
    checkOutput("fl_stall", 64'(stall_cnt), 64'd4);
    checkOutput("fl_sat_stall", 64'(s_stall_cnt), 64'd3);
    applyStimulus(1'b0, 4'b0000, 32'h0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_no_C", 64'(m_valid), 64'h0);
    checkOutput("fl_ready", 64'(e_ready), 64'h1);

    // Flush while EMPTY, with an offered input that must be discarded
    applyStimulus(1'b1, 4'b0100, 32'h77, 3'd1, 1'b1, 1'b1);
    tick();
    checkOutput("fe_valid", 64'(m_valid), 64'h0);
    checkOutput("fe_cnt", 64'(flush_cnt), 64'd1);

    // Further stalls in FULL: 16-bit counter keeps counting, 2-bit one holds at 3
    applyStimulus(1'b1, 4'b0100, 32'hF, 3'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("sat_stall16", 64'(stall_cnt), 64'd6);
    checkOutput("sat_stall2", 64'(s_stall_cnt), 64'd3);
    checkOutput("sat_hold_alu", 64'(ALUResultM), 64'hF);
    checkOutput("sat_hold_valid", 64'(m_valid), 64'h1);

    // Asynchronous reset between edges while FULL
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(m_valid), 64'h0);
    checkOutput("arst_alu", 64'(ALUResultM), 64'h0);
    checkOutput("arst_ctrl", 64'({PCSrcM, RegWriteM, MemWriteM, MemtoRegM}), 64'h0);
    checkOutput("arst_stall", 64'(stall_cnt), 64'h0);
    checkOutput("arst_flush", 64'(flush_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0101, 32'h21, 3'd1, 1'b1, 1'b0);
    tick();
    checkOutput("post_alu1", 64'(ALUResultM), 64'h21);
    checkOutput("post_mtr", 64'(MemtoRegM), 64'h1);
    applyStimulus(1'b1, 4'b0100, 32'h22, 3'd2, 1'b1, 1'b0);
    tick();
    checkOutput("post_alu2", 64'(ALUResultM), 64'h22);
    checkOutput("post_valid", 64'(m_valid), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
